// File: rtl/mod_port_pkg.sv
// Shared definitions for the mod_port memory slave: default sizes,
// response codes, the only accepted beat size and the channel FSM states.
package mod_port_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_MEMORY_DEPTH = 1024;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only 4-byte beats are served; any other size code makes the burst erroneous.
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wrState_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rdState_t;

endpackage

// File: rtl/mod_port_if.sv
// Burst bus between a master and the mod_port slave. The response-valid
// names keep their historical spelling (BVAILD/RVAILD) so existing
// masters connect unchanged.
interface mod_port_if
    import mod_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVAILD;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVAILD;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
        output ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVAILD, ARREADY, RDATA, RRESP, RLAST, RVAILD
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVAILD, ARREADY, RDATA, RRESP, RLAST, RVAILD
    );

endinterface

// File: rtl/mod_port_mem.sv
// Word storage for mod_port: one synchronous write port and one synchronous
// read port. A read and a write to the same word in one cycle returns the
// old contents. Contents are deliberately never reset.
module mod_port_mem
    import mod_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_MEMORY_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Store a word on every enabled write cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Capture a word only when asked, so the output holds while the reader stalls.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mod_port.sv
// Burst memory slave: independent write and read channels sharing one
// word array. Bursts are incrementing, one word per beat. Erroneous bursts
// run their full length but never touch memory and report SLVERR.
module mod_port
    import mod_port_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int MEMORY_DEPTH = DEF_MEMORY_DEPTH
) (
    input  logic      ACLK,
    input  logic      ARESTN,
    mod_port_if.slave bus
);

    localparam int WORD_AW = ADDR_WIDTH - 2;
    localparam int MEM_AW  = $clog2(MEMORY_DEPTH);

    // A burst is bad for a non-word size, running past the array, or crossing a 4 KB page.
    function automatic logic burstError(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [7:0]            len,
                                        input logic [2:0]            size);
        logic [31:0] lastWord;
        logic [31:0] pageEnd;
        lastWord = 32'(addr >> 2) + 32'(len);
        pageEnd  = 32'(addr[11:0]) + ((32'(len) + 32'd1) << 2);
        return (size != SIZE_WORD) || (lastWord >= 32'(MEMORY_DEPTH)) || (pageEnd > 32'd4096);
    endfunction

    wrState_t              r_wrState, w_wrNext;
    logic [WORD_AW-1:0]    r_wrWord;
    logic [7:0]            r_wrLen, r_wrCnt;
    logic                  r_wrErr, r_wrLastErr;
    logic                  w_awReady, w_wReady, w_bValid, w_wrBeat, w_memWe;

    rdState_t              r_rdState, w_rdNext;
    logic [WORD_AW-1:0]    r_rdWord, w_rdNextWord;
    logic [7:0]            r_rdLen, r_rdCnt;
    logic                  r_rdErr;
    logic                  w_arReady, w_rValid, w_memRe;
    logic [MEM_AW-1:0]     w_memRaddr;
    logic [DATA_WIDTH-1:0] w_memRdata;

    // Write channel state register.
    always_ff @(posedge ACLK or posedge ARESTN) begin
        if (ARESTN) r_wrState <= W_IDLE;
        else        r_wrState <= w_wrNext;
    end

    // Write channel sequencing: address, counted data beats, then response.
    always_comb begin
        w_wrNext  = r_wrState;
        w_awReady = 1'b0;
        w_wReady  = 1'b0;
        w_bValid  = 1'b0;
        case (r_wrState)
            W_IDLE: begin
                w_awReady = 1'b1;
                if (bus.AWVALID) w_wrNext = W_DATA;
            end
            W_DATA: begin
                w_wReady = 1'b1;
                if (bus.WVALID && (r_wrCnt == r_wrLen)) w_wrNext = W_RESP;
            end
            W_RESP: begin
                w_bValid = 1'b1;
                if (bus.BREADY) w_wrNext = W_IDLE;
            end
            default: w_wrNext = W_IDLE;
        endcase
    end

    assign w_wrBeat = (r_wrState == W_DATA) && bus.WVALID;
    assign w_memWe  = w_wrBeat && !r_wrErr;

    // Write burst bookkeeping; a missing WLAST on the final beat is remembered for the response.
    always_ff @(posedge ACLK or posedge ARESTN) begin
        if (ARESTN) begin
            r_wrWord    <= '0;
            r_wrLen     <= 8'd0;
            r_wrCnt     <= 8'd0;
            r_wrErr     <= 1'b0;
            r_wrLastErr <= 1'b0;
        end else if ((r_wrState == W_IDLE) && bus.AWVALID) begin
            r_wrWord    <= bus.AWADDR[ADDR_WIDTH-1:2];
            r_wrLen     <= bus.AWLEN;
            r_wrCnt     <= 8'd0;
            r_wrErr     <= burstError(bus.AWADDR, bus.AWLEN, bus.AWSIZE);
            r_wrLastErr <= 1'b0;
        end else if (w_wrBeat) begin
            r_wrWord <= r_wrWord + WORD_AW'(1);
            r_wrCnt  <= r_wrCnt + 8'd1;
            if ((r_wrCnt == r_wrLen) && !bus.WLAST) r_wrLastErr <= 1'b1;
        end
    end

    // Read channel state register.
    always_ff @(posedge ACLK or posedge ARESTN) begin
        if (ARESTN) r_rdState <= R_IDLE;
        else        r_rdState <= w_rdNext;
    end

    assign w_rdNextWord = r_rdWord + WORD_AW'(1);

    // Read sequencing: fetch beat 0 on the address handshake, then fetch the next beat on each accepted beat.
    always_comb begin
        w_rdNext   = r_rdState;
        w_arReady  = 1'b0;
        w_rValid   = 1'b0;
        w_memRe    = 1'b0;
        w_memRaddr = bus.ARADDR[MEM_AW+1:2];
        case (r_rdState)
            R_IDLE: begin
                w_arReady = 1'b1;
                if (bus.ARVALID) begin
                    w_rdNext = R_DATA;
                    w_memRe  = 1'b1;
                end
            end
            R_DATA: begin
                w_rValid = 1'b1;
                if (bus.RREADY) begin
                    if (r_rdCnt == r_rdLen) begin
                        w_rdNext = R_IDLE;
                    end else begin
                        w_memRe    = 1'b1;
                        w_memRaddr = w_rdNextWord[MEM_AW-1:0];
                    end
                end
            end
            default: w_rdNext = R_IDLE;
        endcase
    end

    // Read burst bookkeeping: current word, beat count and error flag.
    always_ff @(posedge ACLK or posedge ARESTN) begin
        if (ARESTN) begin
            r_rdWord <= '0;
            r_rdLen  <= 8'd0;
            r_rdCnt  <= 8'd0;
            r_rdErr  <= 1'b0;
        end else if ((r_rdState == R_IDLE) && bus.ARVALID) begin
            r_rdWord <= bus.ARADDR[ADDR_WIDTH-1:2];
            r_rdLen  <= bus.ARLEN;
            r_rdCnt  <= 8'd0;
            r_rdErr  <= burstError(bus.ARADDR, bus.ARLEN, bus.ARSIZE);
        end else if ((r_rdState == R_DATA) && bus.RREADY && (r_rdCnt != r_rdLen)) begin
            r_rdWord <= w_rdNextWord;
            r_rdCnt  <= r_rdCnt + 8'd1;
        end
    end

    mod_port_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMORY_DEPTH),
        .AW         (MEM_AW)
    ) u_mem (
        .i_clk   (ACLK),
        .i_we    (w_memWe),
        .i_waddr (r_wrWord[MEM_AW-1:0]),
        .i_wdata (bus.WDATA),
        .i_re    (w_memRe),
        .i_raddr (w_memRaddr),
        .o_rdata (w_memRdata)
    );

    assign bus.AWREADY = w_awReady && !ARESTN;
    assign bus.WREADY  = w_wReady;
    assign bus.BVAILD  = w_bValid;
    assign bus.BRESP   = (w_bValid && (r_wrErr || r_wrLastErr)) ? RESP_SLVERR : RESP_OKAY;
    assign bus.ARREADY = w_arReady && !ARESTN;
    assign bus.RVAILD  = w_rValid;
    assign bus.RDATA   = (w_rValid && !r_rdErr) ? w_memRdata : '0;
    assign bus.RRESP   = (w_rValid && r_rdErr) ? RESP_SLVERR : RESP_OKAY;
    assign bus.RLAST   = w_rValid && (r_rdCnt == r_rdLen);

endmodule

// File: tb/tb_mod_port.sv
// Self-checking bench for mod_port. A plain word array plus an error rule
// written from the burst rules predicts every response and read word.
module tb_mod_port;
    import mod_port_pkg::*;

    localparam int DEPTH = 1024;
    localparam int TMO   = 60;

    logic ACLK   = 1'b0;
    logic ARESTN = 1'b1;

    int errCount   = 0;
    int checkCount = 0;

    logic [31:0] expMem [DEPTH];

    mod_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    mod_port #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (16),
        .MEMORY_DEPTH (DEPTH)
    ) dut (
        .ACLK   (ACLK),
        .ARESTN (ARESTN),
        .bus    (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 ACLK = ~ACLK;

    // Hard stop in case a handshake never resolves.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts every comparison and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Burst rules as arithmetic: word size only, stay inside the array, stay inside one 4 KB page.
    function automatic logic modelErr(input int addr, input int len, input int size);
        return (size != 2) || ((addr / 4 + len) >= DEPTH) || ((addr % 4096) + (len + 1) * 4 > 4096);
    endfunction

    // Issue one write burst, update the reference array and check the response.
    task automatic writeBurst(input int addr, input int len, input int size, input logic lastOk,
                              input logic useFixed, input logic [31:0] base);
        int t;
        int n;
        logic expErr;
        logic [31:0] d;
        logic [1:0] resp;
        expErr = modelErr(addr, len, size);
        @(negedge ACLK);
        bus.AWADDR  = 16'(addr);
        bus.AWLEN   = 8'(len);
        bus.AWSIZE  = 3'(size);
        bus.AWVALID = 1'b1;
        t = 0;
        while (!bus.AWREADY && t < TMO) begin @(negedge ACLK); t++; end
        checkOutput("awReady", 64'(bus.AWREADY), 64'(1));
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.WVALID = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge ACLK);
            end
            d = useFixed ? base + 32'(i) : $urandom;
            bus.WDATA  = d;
            bus.WLAST  = (i == len) ? lastOk : 1'($urandom_range(0, 1));
            bus.WVALID = 1'b1;
            t = 0;
            while (!bus.WREADY && t < TMO) begin @(negedge ACLK); t++; end
            checkOutput("wReady", 64'(bus.WREADY), 64'(1));
            @(negedge ACLK);
            if (!expErr) expMem[addr / 4 + i] = d;
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        t = 0;
        while (!bus.BVAILD && t < TMO) begin @(negedge ACLK); t++; end
        checkOutput("bValid", 64'(bus.BVAILD), 64'(1));
        resp = bus.BRESP;
        checkOutput("bResp", 64'(resp), (expErr || !lastOk) ? 64'(2) : 64'(0));
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            @(negedge ACLK);
            checkOutput("bHold", 64'({bus.BVAILD, bus.BRESP}), 64'({1'b1, resp}));
        end
        bus.BREADY = 1'b1;
        @(negedge ACLK);
        bus.BREADY = 1'b0;
        checkOutput("bDone", 64'(bus.BVAILD), 64'(0));
    endtask

    // Issue one read burst; mode 0 = always ready, 1 = ready toggles, 2 = random ready.
    task automatic readBurst(input int addr, input int len, input int size, input int mode);
        int t;
        int beat;
        logic expErr;
        logic tog;
        logic rr;
        logic stalled;
        logic [34:0] held;
        logic [31:0] expData;
        expErr  = modelErr(addr, len, size);
        tog     = 1'b0;
        stalled = 1'b0;
        held    = '0;
        @(negedge ACLK);
        bus.ARADDR  = 16'(addr);
        bus.ARLEN   = 8'(len);
        bus.ARSIZE  = 3'(size);
        bus.ARVALID = 1'b1;
        t = 0;
        while (!bus.ARREADY && t < TMO) begin @(negedge ACLK); t++; end
        checkOutput("arReady", 64'(bus.ARREADY), 64'(1));
        @(negedge ACLK);
        bus.ARVALID = 1'b0;
        checkOutput("rLatency", 64'(bus.RVAILD), 64'(1));
        beat = 0;
        t = 0;
        while (beat <= len && t < TMO * 4) begin
            if (bus.RVAILD) begin
                if (stalled)
                    checkOutput("rHold", 64'({bus.RDATA, bus.RRESP, bus.RLAST}), 64'(held));
                if (mode == 0)      rr = 1'b1;
                else if (mode == 1) begin rr = tog; tog = !tog; end
                else                rr = 1'($urandom_range(0, 1));
                bus.RREADY = rr;
                if (rr) begin
                    expData = expErr ? 32'd0 : expMem[addr / 4 + beat];
                    checkOutput("rData", 64'(bus.RDATA), 64'(expData));
                    checkOutput("rResp", 64'(bus.RRESP), expErr ? 64'(2) : 64'(0));
                    checkOutput("rLast", 64'(bus.RLAST), 64'(beat == len));
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = {bus.RDATA, bus.RRESP, bus.RLAST};
                end
            end else begin
                bus.RREADY = 1'b0;
            end
            @(negedge ACLK);
            t++;
        end
        bus.RREADY = 1'b0;
        checkOutput("rBeats", 64'(beat), 64'(len + 1));
        checkOutput("rDone", 64'(bus.RVAILD), 64'(0));
    endtask

    // Randomized mix of good and bad bursts in both directions.
    task automatic applyStimulus(input int count);
        int sel;
        int w;
        int addr;
        int len;
        int size;
        for (int i = 0; i < count; i++) begin
            sel  = $urandom_range(0, 9);
            w    = $urandom_range(0, 255);
            addr = w * 4;
            len  = $urandom_range(0, ((255 - w) < 15) ? (255 - w) : 15);
            size = 2;
            if (sel == 0) begin
                size = $urandom_range(0, 6);
                if (size >= 2) size++;
            end else if (sel == 1) begin
                addr = 32'h0FF0 + 4 * $urandom_range(0, 3);
                len  = $urandom_range(4, 10);
            end else if (sel == 2) begin
                addr = 32'h1000 + 4 * $urandom_range(0, 255);
            end
            if ($urandom_range(0, 1) == 1)
                writeBurst(addr, len, size, ($urandom_range(0, 5) != 0), 1'b0, 32'd0);
            else
                readBurst(addr, len, size, $urandom_range(0, 2));
        end
    endtask

    // Main sequence: reset, directed scenarios, random traffic, summary.
    initial begin
        int t;
        bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWVALID = 1'b0;
        bus.WDATA  = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        // Outputs must all be quiet while reset is held, then both address channels open.
        repeat (3) @(negedge ACLK);
        checkOutput("rstOutputs", 64'({bus.AWREADY, bus.WREADY, bus.BVAILD, bus.BRESP, bus.ARREADY,
                                      bus.RVAILD, bus.RDATA, bus.RRESP, bus.RLAST}), 64'(0));
        ARESTN = 1'b0;
        @(negedge ACLK);
        checkOutput("awReadyRst", 64'(bus.AWREADY), 64'(1));
        checkOutput("arReadyRst", 64'(bus.ARREADY), 64'(1));

        // Fill the low 256 words so later reads have known contents.
        for (int b = 0; b < 16; b++) writeBurst(b * 64, 15, 2, 1'b1, 1'b0, 32'd0);

        // Directed four-beat write and readback.
        writeBurst(32'h0010, 3, 2, 1'b1, 1'b1, 32'h0000_00A0);
        readBurst(32'h0010, 3, 2, 0);
        checkOutput("directA2", 64'(expMem[6]), 64'(32'hA2));

        // Narrow beat size is rejected and memory keeps its old word.
        writeBurst(32'h0040, 0, 1, 1'b1, 1'b1, 32'hDEAD_0000);
        readBurst(32'h0040, 0, 2, 0);

        // Page crossing read returns zeros with SLVERR for all beats.
        readBurst(32'h0FF8, 3, 2, 0);

        // Last word of the array is reachable.
        writeBurst(32'h0FFC, 0, 2, 1'b1, 1'b0, 32'd0);
        readBurst(32'h0FFC, 0, 2, 2);

        // Missing WLAST on the final beat still writes but reports SLVERR.
        writeBurst(32'h0080, 1, 2, 1'b0, 1'b1, 32'h0000_0B00);
        readBurst(32'h0080, 1, 2, 0);

        // Stalling reader with RREADY alternating.
        readBurst(32'h0010, 3, 2, 1);

        // Write and read channels running side by side.
        fork
            writeBurst(32'h0100, 3, 2, 1'b1, 1'b1, 32'h0000_1100);
            readBurst(32'h0200, 3, 2, 2);
        join
        readBurst(32'h0100, 3, 2, 0);

        // Reset in the middle of a write burst.
        @(negedge ACLK);
        bus.AWADDR = 16'h0300; bus.AWLEN = 8'd3; bus.AWSIZE = 3'd2; bus.AWVALID = 1'b1;
        t = 0;
        while (!bus.AWREADY && t < TMO) begin @(negedge ACLK); t++; end
        checkOutput("awReadyMid", 64'(bus.AWREADY), 64'(1));
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.WDATA = 32'hC0 + 32'(i); bus.WLAST = 1'b0; bus.WVALID = 1'b1;
            t = 0;
            while (!bus.WREADY && t < TMO) begin @(negedge ACLK); t++; end
            checkOutput("wReadyMid", 64'(bus.WREADY), 64'(1));
            @(negedge ACLK);
            expMem[192 + i] = 32'hC0 + 32'(i);
        end
        bus.WDATA = 32'hC2; bus.WVALID = 1'b1;
        ARESTN = 1'b1;
        #1;
        checkOutput("midRstOutputs", 64'({bus.AWREADY, bus.WREADY, bus.BVAILD, bus.BRESP, bus.ARREADY,
                                         bus.RVAILD, bus.RDATA, bus.RRESP, bus.RLAST}), 64'(0));
        @(negedge ACLK);
        bus.WVALID = 1'b0;
        checkOutput("midRstHeld", 64'({bus.AWREADY, bus.WREADY, bus.BVAILD}), 64'(0));
        ARESTN = 1'b0;
        @(negedge ACLK);
        checkOutput("awReadyRelease", 64'(bus.AWREADY), 64'(1));
        checkOutput("wReadyRelease", 64'(bus.WREADY), 64'(0));
        readBurst(32'h0300, 1, 2, 0);
        writeBurst(32'h0300, 3, 2, 1'b1, 1'b1, 32'h0000_00D0);
        readBurst(32'h0300, 3, 2, 2);

        applyStimulus(60);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
